preadd_mul_arbiter: RTL and testbench

- Shares one pipelined signed pre-add/multiply unit, y = (a + b) * c, between NUM_REQ requesters.
- Per-requester valid/ready inputs; round-robin grant; results tagged with the requester ID.
- Results go to an output FIFO with valid/ready. A credit check guarantees the FIFO never overflows under backpressure.
- Sits between the per-channel operand sources and the downstream result consumer.

---
 rtl/preadd_mul_arbiter_if.sv | 30 +++
 rtl/preadd_mul_arbiter.sv | 139 +++++++++++++
 tb/tb_preadd_mul_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/preadd_mul_arbiter_if.sv
// Handshake and data bundle between the operand sources, the shared
// pre-add/multiply arbiter and the downstream result consumer.
interface preadd_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 23,
    parameter int C_W     = 17
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int Y_W  = A_W + 1 + C_W;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*A_W-1:0] req_b;
    logic [NUM_REQ*C_W-1:0] req_c;
    logic                   out_valid;
    logic                   out_ready;
    logic [Y_W-1:0]         out_y;
    logic [ID_W-1:0]        out_id;

    modport master (
        output req_valid, req_a, req_b, req_c, out_ready,
        input  req_ready, out_valid, out_y, out_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, out_ready,
        output req_ready, out_valid, out_y, out_id
    );
endinterface

// File: rtl/preadd_mul_arbiter.sv
// Round-robin shared y = (a + b) * c unit with a credit-protected result FIFO.
// Define PREADD_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module preadd_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int A_W        = 23,
    parameter int C_W        = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    preadd_mul_arbiter_if.slave bus,
    output logic               busy
`ifdef PREADD_ARB_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int Y_W   = A_W + 1 + C_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant_idx;
    logic                   grant_found;
    logic [NUM_REQ-1:0]     ready_vec;
    logic                   credit_ok;
    logic                   accept;

    logic                   s0_v;
    logic signed [A_W-1:0]  s0_a;
    logic signed [A_W-1:0]  s0_b;
    logic signed [C_W-1:0]  s0_c;
    logic [ID_W-1:0]        s0_id;
    logic                   s1_v;
    logic signed [A_W:0]    s1_sum;
    logic signed [C_W-1:0]  s1_c;
    logic [ID_W-1:0]        s1_id;
    logic signed [Y_W-1:0]  product;

    logic [Y_W+ID_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   push;
    logic                   pop;

    // Every accepted item holds a FIFO slot from acceptance until it is popped.
    assign credit_ok = (int'(count) + int'(s0_v) + int'(s1_v)) < FIFO_DEPTH;

    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        ready_vec   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
        if (grant_found && credit_ok && !reset) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready = ready_vec;
    assign accept        = |(bus.req_valid & ready_vec);

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_v   <= 1'b0;
            s1_v   <= 1'b0;
            rr_ptr <= '0;
        end else begin
            s0_v <= accept;
            s1_v <= s0_v;
            if (accept) begin
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s0_a  <= bus.req_a[int'(grant_idx)*A_W +: A_W];
            s0_b  <= bus.req_b[int'(grant_idx)*A_W +: A_W];
            s0_c  <= bus.req_c[int'(grant_idx)*C_W +: C_W];
            s0_id <= grant_idx;
        end
        s1_sum <= {s0_a[A_W-1], s0_a} + {s0_b[A_W-1], s0_b};
        s1_c   <= s0_c;
        s1_id  <= s0_id;
        if (push) begin
            fifo_mem[wr_ptr] <= {s1_id, product};
        end
    end

    assign product = $signed({{C_W{s1_sum[A_W]}}, s1_sum})
                   * $signed({{(A_W+1){s1_c[C_W-1]}}, s1_c});

    assign push = s1_v;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.out_valid            = (count != '0);
    assign {bus.out_id, bus.out_y}  = bus.out_valid ? fifo_mem[rd_ptr] : '0;
    assign busy                     = s0_v | s1_v | bus.out_valid;

    a_no_push_on_full: assert property (@(posedge clk) disable iff (reset)
        !(push && count == CNT_W'(FIFO_DEPTH)));

`ifdef PREADD_ARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((|bus.req_valid) && !credit_ok && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_preadd_mul_arbiter.sv
// Directed bench for preadd_mul_arbiter: a queue model of outstanding results
// checked every cycle, plus literal expectations from hand-worked cases.
module tb_preadd_mul_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int A_W        = 23;
    localparam int C_W        = 17;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
`ifdef PREADD_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
    int          stall_m = 0;
`endif

    preadd_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .A_W(A_W), .C_W(C_W)) bus ();

    preadd_mul_arbiter #(.NUM_REQ(NUM_REQ), .A_W(A_W), .C_W(C_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
`ifdef PREADD_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        longint y;
        int     id;
        int     acc;
    } item_t;
    item_t expq[$];
    int    ptr_m = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Model: credit is free iff fewer than FIFO_DEPTH results are outstanding;
    // a result becomes visible three cycles after acceptance, in acceptance order.
    always @(negedge clk) begin : cmp
        logic [NUM_REQ-1:0]    exp_ready;
        logic                  exp_ov;
        int                    g;
        logic signed [A_W-1:0] av, bv;
        logic signed [C_W-1:0] cv;
        item_t                 it;
        exp_ready = '0;
        g = -1;
        if (reset) begin
            check("ready_in_reset", bus.req_ready, 0);
            expq.delete();
            ptr_m = 0;
`ifdef PREADD_ARB_STALL_CNT_EN
            stall_m = 0;
`endif
        end else begin
            if (expq.size() < FIFO_DEPTH) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && bus.req_valid[(ptr_m + k) % NUM_REQ]) g = (ptr_m + k) % NUM_REQ;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", bus.req_ready, exp_ready);
            exp_ov = (expq.size() > 0) && (cyc >= expq[0].acc + 3);
            check("out_valid", bus.out_valid, exp_ov);
            check("busy", busy, expq.size() > 0);
            if (exp_ov) begin
                check("out_y", longint'($signed(bus.out_y)), expq[0].y);
                check("out_id", bus.out_id, expq[0].id);
            end
`ifdef PREADD_ARB_STALL_CNT_EN
            check("stall_cnt", stall_cnt, stall_m);
            if ((|bus.req_valid) && expq.size() >= FIFO_DEPTH && stall_m < 16'hFFFF) stall_m++;
`endif
            if (exp_ov && bus.out_ready) void'(expq.pop_front());
            if (g >= 0) begin
                av = bus.req_a[g*A_W +: A_W];
                bv = bus.req_b[g*A_W +: A_W];
                cv = bus.req_c[g*C_W +: C_W];
                it.y   = (longint'(av) + longint'(bv)) * longint'(cv);
                it.id  = g;
                it.acc = cyc;
                expq.push_back(it);
                ptr_m = (g + 1) % NUM_REQ;
            end
        end
    end

    task automatic set_ops(input int i, input longint a, input longint b, input longint c);
        bus.req_a[i*A_W +: A_W] = A_W'(a);
        bus.req_b[i*A_W +: A_W] = A_W'(b);
        bus.req_c[i*C_W +: C_W] = C_W'(c);
    endtask

    // Call at posedge+1; returns the acceptance cycle and drops valid afterwards.
    task automatic issue_one(input int i, input longint a, input longint b, input longint c,
                             output int acc);
        int w = 0;
        acc = -1;
        set_ops(i, a, b, c);
        bus.req_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            if (bus.req_ready[i]) acc = cyc;
            else begin @(posedge clk); #1; end
            w++;
        end while (acc < 0 && w < 30);
        if (acc < 0) check("issue_timeout", bus.req_ready[i], 1);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic expect_result(input string nm, input longint y, input int id);
        int w = 0;
        @(negedge clk);
        while (!bus.out_valid && w < 20) begin @(negedge clk); w++; end
        check({nm, "_valid"}, bus.out_valid, 1);
        check({nm, "_y"}, longint'($signed(bus.out_y)), y);
        check({nm, "_id"}, bus.out_id, id);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (busy && w < 40) begin @(negedge clk); w++; end
        check("drain_idle", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, grants, g;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_y", bus.out_y, 0);
        check("rst_out_id", bus.out_id, 0);
        @(posedge clk); #1;

        // Single request: (100 - 20) * 3 = 240, visible exactly at n+3.
        bus.out_ready = 1'b1;
        issue_one(0, 100, -20, 3, acc);
        @(negedge clk);
        for (int w = 0; w < 10 && cyc < acc + 2; w++) @(negedge clk);
        check("single_not_early", bus.out_valid, 0);
        @(negedge clk);
        check("single_latency_cyc", cyc, acc + 3);
        check("single_valid", bus.out_valid, 1);
        check("single_y", longint'($signed(bus.out_y)), 240);
        check("single_id", bus.out_id, 0);
        @(negedge clk);
        check("single_busy_low", busy, 0);
        @(posedge clk); #1;

        // Operand extremes.
        issue_one(1, -4194304, -4194304, -65536, acc);
        expect_result("ext_max", 64'sd549755813888, 1);
        issue_one(2, 4194303, 0, -1, acc);
        expect_result("ext_neg", -64'sd4194303, 2);
        wait_idle();

        // Reset restarts the pointer at 0, then round-robin over all four.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, 10 * (i + 1), -3, i - 2);
        bus.req_valid = '1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j < 6) check("rr_grant", onehot_idx(bus.req_ready), j % 4);
            if (j >= 3) begin
                check("rr_out_valid", bus.out_valid, 1);
                check("rr_out_id", bus.out_id, (j - 3) % 4);
            end
            @(posedge clk); #1;
            if (j == 5) bus.req_valid = '0;
        end
        wait_idle();

        // Backpressure: four acceptances then no credit.
        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, -7 * i, 1000 + i, 3 - i);
        bus.req_valid = '1;
        grants = 0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) grants++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_accepts", grants, 4);
        check("bp_ready_low", bus.req_ready, 0);
`ifdef PREADD_ARB_STALL_CNT_EN
        check("bp_stall_cnt", stall_cnt, 10);
`endif
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_valid", bus.out_valid, 1);
        check("bp_no_credit_on_pop", bus.req_ready, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        grants = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) check("bp_regrant", |bus.req_ready, 1);
            if (|(bus.req_valid & bus.req_ready)) grants++;
            @(posedge clk); #1;
        end
        check("bp_one_regrant", grants, 1);
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        wait_idle();

        // Reset with one result in the FIFO and two in the pipeline.
        bus.out_ready = 1'b0;
        bus.req_valid = '1;
        grants = 0;
        for (int w = 0; w < 20 && grants < 3; w++) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) grants++;
            @(posedge clk); #1;
        end
        check("mid_accepts", grants, 3);
        bus.req_valid = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_busy", busy, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("mid_no_stale", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        set_ops(0, 5, 6, -2);
        bus.req_valid = '1;
        @(negedge clk);
        g = onehot_idx(bus.req_ready);
        check("mid_ptr_restart", g, 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        expect_result("mid_after", -22, 0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
